// File: rtl/game_pkg.sv
// Shared types and defaults for the duck-game controller: state encoding,
// play-button geometry defaults and the RGB bus width.
package game_pkg;

    localparam int unsigned RGB_W  = 12;
    localparam int unsigned GEOM_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GAME  = 2'd2,
        ST_SCORE = 2'd3
    } state_e;

    localparam logic [GEOM_W-1:0] DEF_BTN_HSTART = 11'd380;
    localparam logic [GEOM_W-1:0] DEF_BTN_VSTART = 11'd186;
    localparam logic [GEOM_W-1:0] DEF_BTN_HLEN   = 11'd300;
    localparam logic [GEOM_W-1:0] DEF_BTN_VLEN   = 11'd100;

endpackage

// File: rtl/game_fsm_param_if.sv
// Control, pixel and status bundle between the game controller and its
// environment. The controller sits on the slave modport.
interface game_fsm_param_if #(
    parameter int unsigned TIME_W  = 7,
    parameter int unsigned ROUND_W = 2,
    parameter int unsigned SCORE_W = 8,
    parameter int unsigned RGB_W   = game_pkg::RGB_W
);
    logic                       play_clicked;
    logic                       uart_start;
    logic                       stop_clicked;
    logic                       duck_hit;
    logic [RGB_W-1:0]           rgb_idle;
    logic [RGB_W-1:0]           rgb_wait;
    logic [RGB_W-1:0]           rgb_game;
    logic [RGB_W-1:0]           rgb_score;
    logic [RGB_W-1:0]           rgb_out;
    logic [1:0]                 state;
    logic [TIME_W-1:0]          time_left;
    logic [ROUND_W-1:0]         round_idx;
    logic [SCORE_W-1:0]         score;
    logic                       round_end;
    logic [game_pkg::GEOM_W-1:0] btn_hstart;
    logic [game_pkg::GEOM_W-1:0] btn_vstart;
    logic [game_pkg::GEOM_W-1:0] btn_hlen;
    logic [game_pkg::GEOM_W-1:0] btn_vlen;

    modport master (
        output play_clicked, uart_start, stop_clicked, duck_hit,
        output rgb_idle, rgb_wait, rgb_game, rgb_score,
        input  rgb_out, state, time_left, round_idx, score, round_end,
        input  btn_hstart, btn_vstart, btn_hlen, btn_vlen
    );

    modport slave (
        input  play_clicked, uart_start, stop_clicked, duck_hit,
        input  rgb_idle, rgb_wait, rgb_game, rgb_score,
        output rgb_out, state, time_left, round_idx, score, round_end,
        output btn_hstart, btn_vstart, btn_hlen, btn_vlen
    );

endinterface

// File: rtl/round_timer.sv
// Round timer: prescaler producing a tick every TICK_DIV clocks while running,
// and a down-counter of ticks left in the round with expiry detection.
module round_timer #(
    parameter int unsigned TICK_DIV = 65_000_000,
    parameter int unsigned TIME_W   = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic              load_i,
    input  logic [TIME_W-1:0] game_time_i,
    output logic              tick_o,
    output logic [TIME_W-1:0] time_left_o,
    output logic              expired_o
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [TIME_W-1:0]  time_q, time_d;

    assign tick_o      = run_i && (presc_q == PRESC_MAX);
    assign expired_o   = tick_o && (time_q == TIME_W'(1));
    assign time_left_o = time_q;

    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        if (load_i) begin
            presc_d = '0;
            time_d  = game_time_i;
        end else if (!run_i) begin
            presc_d = '0;
        end else begin
            presc_d = tick_o ? '0 : presc_q + 1'b1;
            // Expiry lands here too: time_left 1 -> 0 on the final tick.
            if (tick_o && (time_q != '0)) begin
                time_d = time_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            time_q  <= '0;
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
        end
    end

endmodule

// File: rtl/game_fsm_param.sv
// Duck-game top controller: IDLE/WAIT/GAME/SCORE sequencing, multi-round play,
// saturating hit score, registered pixel source select and play-button geometry.
module game_fsm_param
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 65_000_000,
    parameter int unsigned GAME_TIME  = 60,
    parameter int unsigned ROUNDS     = 1,
    parameter int unsigned TIME_W     = 7,
    parameter int unsigned ROUND_W    = 2,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned RGB_W      = game_pkg::RGB_W,
    parameter int unsigned BTN_HSTART = DEF_BTN_HSTART,
    parameter int unsigned BTN_VSTART = DEF_BTN_VSTART,
    parameter int unsigned BTN_HLEN   = DEF_BTN_HLEN,
    parameter int unsigned BTN_VLEN   = DEF_BTN_VLEN
) (
    input logic               pclk,
    input logic               rst_n,
    game_fsm_param_if.slave   io
);

    localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(GAME_TIME);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

    state_e             state_q;
    logic [ROUND_W-1:0] round_q;
    logic [SCORE_W-1:0] score_q;
    logic               round_end_q;
    logic [RGB_W-1:0]   rgb_q;
    logic [GEOM_W-1:0]  hstart_q, vstart_q, hlen_q, vlen_q;

    logic              tmr_run, tmr_load, tmr_tick, tmr_expired;
    logic [TIME_W-1:0] time_left;
    logic              last_round;

    assign last_round = (round_q == LAST_ROUND);
    assign tmr_run    = (state_q == ST_GAME);
    // Reload for the next round only when the expiry is not pre-empted by an abort.
    assign tmr_load   = ((state_q == ST_WAIT) && io.uart_start) ||
                        (tmr_expired && !io.stop_clicked && !last_round);

    round_timer #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
    ) u_round_timer (
        .clk_i       (pclk),
        .rst_ni      (rst_n),
        .run_i       (tmr_run),
        .load_i      (tmr_load),
        .game_time_i (TIME_INIT),
        .tick_o      (tmr_tick),
        .time_left_o (time_left),
        .expired_o   (tmr_expired)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            round_q     <= '0;
            score_q     <= '0;
            round_end_q <= 1'b0;
            rgb_q       <= '0;
            hstart_q    <= '0;
            vstart_q    <= '0;
            hlen_q      <= '0;
            vlen_q      <= '0;
        end else begin
            round_end_q <= tmr_tick && tmr_expired;

            case (state_q)
                ST_WAIT:  rgb_q <= io.rgb_wait;
                ST_GAME:  rgb_q <= io.rgb_game;
                ST_SCORE: rgb_q <= io.rgb_score;
                default:  rgb_q <= io.rgb_idle;
            endcase

            if (state_q == ST_IDLE) begin
                hstart_q <= GEOM_W'(BTN_HSTART);
                vstart_q <= GEOM_W'(BTN_VSTART);
                hlen_q   <= GEOM_W'(BTN_HLEN);
                vlen_q   <= GEOM_W'(BTN_VLEN);
            end else begin
                hstart_q <= '0;
                vstart_q <= '0;
                hlen_q   <= '0;
                vlen_q   <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (io.play_clicked) begin
                        state_q <= ST_WAIT;
                        score_q <= '0;
                        round_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (io.uart_start) begin
                        state_q <= ST_GAME;
                    end
                end
                ST_GAME: begin
                    if (io.duck_hit && (score_q != {SCORE_W{1'b1}})) begin
                        score_q <= score_q + 1'b1;
                    end
                    if (io.stop_clicked) begin
                        state_q <= ST_SCORE;
                    end else if (tmr_expired) begin
                        if (last_round) begin
                            state_q <= ST_SCORE;
                        end else begin
                            round_q <= round_q + 1'b1;
                        end
                    end
                end
                ST_SCORE: begin
                    if (io.stop_clicked) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign io.state      = state_q;
    assign io.time_left  = time_left;
    assign io.round_idx  = round_q;
    assign io.score      = score_q;
    assign io.round_end  = round_end_q;
    assign io.rgb_out    = rgb_q;
    assign io.btn_hstart = hstart_q;
    assign io.btn_vstart = vstart_q;
    assign io.btn_hlen   = hlen_q;
    assign io.btn_vlen   = vlen_q;

endmodule

// File: tb/tb_game_fsm_param.sv
// Bench for game_fsm_param: a cycle model of the game rules checked against the
// DUT on every negative edge, plus directed scenarios with literal expectations.
module tb_game_fsm_param;

    localparam int TD = 4;
    localparam int GT = 3;
    localparam int NR = 2;
    localparam int SW = 3;

    localparam logic [11:0] C_IDLE  = 12'h111;
    localparam logic [11:0] C_WAIT  = 12'h222;
    localparam logic [11:0] C_GAME  = 12'h333;
    localparam logic [11:0] C_SCORE = 12'h444;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;

    game_fsm_param_if #(
        .TIME_W  (7),
        .ROUND_W (2),
        .SCORE_W (SW),
        .RGB_W   (12)
    ) bus ();

    game_fsm_param #(
        .TICK_DIV  (TD),
        .GAME_TIME (GT),
        .ROUNDS    (NR),
        .TIME_W    (7),
        .ROUND_W   (2),
        .SCORE_W   (SW),
        .RGB_W     (12)
    ) u_dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: game rules in plain integer arithmetic.
    int          m_state = 0;
    int          m_tl    = 0;
    int          m_round = 0;
    int          m_score = 0;
    int          m_cyc   = 0;
    int          m_old   = 0;
    bit          m_tick  = 0;
    bit          m_exp   = 0;
    bit          m_rend  = 0;
    bit          m_geom  = 0;
    logic [11:0] m_rgb   = '0;

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_tl = 0; m_round = 0; m_score = 0; m_cyc = 0;
            m_rend = 0; m_geom = 0; m_rgb = '0;
        end else begin
            m_old  = m_state;
            m_rgb  = (m_old == 0) ? C_IDLE : (m_old == 1) ? C_WAIT :
                     (m_old == 2) ? C_GAME : C_SCORE;
            m_geom = (m_old == 0);
            m_rend = 0;
            case (m_old)
                0: if (bus.play_clicked) begin
                    m_state = 1; m_score = 0; m_round = 0;
                end
                1: if (bus.uart_start) begin
                    m_state = 2; m_tl = GT; m_cyc = 0;
                end
                2: begin
                    m_cyc++;
                    m_tick = (m_cyc % TD) == 0;
                    m_exp  = m_tick && (m_tl == 1);
                    m_rend = m_exp;
                    if (bus.duck_hit && m_score < (1 << SW) - 1) m_score++;
                    if (m_tick && m_tl > 0) m_tl--;
                    if (bus.stop_clicked) begin
                        m_state = 3;
                    end else if (m_exp) begin
                        if (m_round < NR - 1) begin
                            m_round++; m_tl = GT; m_cyc = 0;
                        end else begin
                            m_state = 3;
                        end
                    end
                end
                default: if (bus.stop_clicked) m_state = 0;
            endcase
        end
    end

    always @(negedge pclk) begin
        check("state",      32'(bus.state),      32'(m_state));
        check("time_left",  32'(bus.time_left),  32'(m_tl));
        check("round_idx",  32'(bus.round_idx),  32'(m_round));
        check("score",      32'(bus.score),      32'(m_score));
        check("round_end",  32'(bus.round_end),  32'(m_rend));
        check("rgb_out",    32'(bus.rgb_out),    32'(m_rgb));
        check("btn_hstart", 32'(bus.btn_hstart), m_geom ? 32'd380 : 32'd0);
        check("btn_vstart", 32'(bus.btn_vstart), m_geom ? 32'd186 : 32'd0);
        check("btn_hlen",   32'(bus.btn_hlen),   m_geom ? 32'd300 : 32'd0);
        check("btn_vlen",   32'(bus.btn_vlen),   m_geom ? 32'd100 : 32'd0);
    end

    task automatic step();
        @(posedge pclk);
        #2;
    endtask

    task automatic wait_round_end(output bit seen);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.round_end === 1'b1) begin
                seen = 1;
                break;
            end
        end
    endtask

    bit seen;

    initial begin
        bus.play_clicked = 0;
        bus.uart_start   = 0;
        bus.stop_clicked = 0;
        bus.duck_hit     = 0;
        bus.rgb_idle     = C_IDLE;
        bus.rgb_wait     = C_WAIT;
        bus.rgb_game     = C_GAME;
        bus.rgb_score    = C_SCORE;

        repeat (2) @(posedge pclk);
        #3;
        check("rst_state", 32'(bus.state), 0);
        check("rst_score", 32'(bus.score), 0);
        check("rst_rgb", 32'(bus.rgb_out), 0);
        check("rst_geom", 32'(bus.btn_hstart), 0);
        @(posedge pclk);
        #2 rst_n = 1;

        step();
        check("idle_hstart", 32'(bus.btn_hstart), 380);
        check("idle_vlen", 32'(bus.btn_vlen), 100);
        check("idle_rgb", 32'(bus.rgb_out), 32'(C_IDLE));

        bus.duck_hit = 1; step(); bus.duck_hit = 0;
        check("idle_hit_ignored", 32'(bus.score), 0);

        bus.play_clicked = 1; step(); bus.play_clicked = 0;
        check("to_wait", 32'(bus.state), 1);
        bus.play_clicked = 1; bus.duck_hit = 1; step();
        bus.play_clicked = 0; bus.duck_hit = 0;
        check("wait_play_ignored", 32'(bus.state), 1);
        check("wait_hit_ignored", 32'(bus.score), 0);
        check("wait_geom_zero", 32'(bus.btn_hstart), 0);

        bus.uart_start = 1; step(); bus.uart_start = 0;
        check("to_game", 32'(bus.state), 2);
        check("game_tl", 32'(bus.time_left), 3);

        bus.duck_hit = 1; repeat (10) step(); bus.duck_hit = 0;
        check("score_sat", 32'(bus.score), 7);

        wait_round_end(seen);
        check("round0_end_seen", 32'(seen), 1);
        check("round1_idx", 32'(bus.round_idx), 1);
        check("round1_tl", 32'(bus.time_left), 3);
        check("round1_state", 32'(bus.state), 2);

        wait_round_end(seen);
        check("round1_end_seen", 32'(seen), 1);
        check("end_state", 32'(bus.state), 3);
        check("end_tl", 32'(bus.time_left), 0);
        step();
        check("round_end_one_cycle", 32'(bus.round_end), 0);

        bus.duck_hit = 1; step(); bus.duck_hit = 0;
        check("score_hit_ignored", 32'(bus.score), 7);
        bus.stop_clicked = 1; step(); bus.stop_clicked = 0;
        check("score_to_idle", 32'(bus.state), 0);
        check("score_held", 32'(bus.score), 7);

        // Abort in the very cycle round 0 expires.
        bus.play_clicked = 1; step(); bus.play_clicked = 0;
        bus.uart_start = 1; step(); bus.uart_start = 0;
        repeat (11) step();
        bus.stop_clicked = 1; step(); bus.stop_clicked = 0;
        check("abort_state", 32'(bus.state), 3);
        check("abort_round", 32'(bus.round_idx), 0);
        check("abort_round_end", 32'(bus.round_end), 1);
        check("abort_score_cleared", 32'(bus.score), 0);
        bus.stop_clicked = 1; step(); bus.stop_clicked = 0;

        // Asynchronous reset in the middle of a game.
        bus.play_clicked = 1; step(); bus.play_clicked = 0;
        bus.uart_start = 1; step(); bus.uart_start = 0;
        bus.duck_hit = 1; repeat (2) step(); bus.duck_hit = 0;
        repeat (3) step();
        #1 rst_n = 0;
        #1;
        check("arst_state", 32'(bus.state), 0);
        check("arst_tl", 32'(bus.time_left), 0);
        check("arst_score", 32'(bus.score), 0);
        check("arst_rgb", 32'(bus.rgb_out), 0);
        check("arst_geom", 32'(bus.btn_hstart), 0);
        @(posedge pclk);
        #2 rst_n = 1;
        step();
        bus.play_clicked = 1; step(); bus.play_clicked = 0;
        bus.uart_start = 1; step(); bus.uart_start = 0;
        check("replay_state", 32'(bus.state), 2);
        check("replay_tl", 32'(bus.time_left), 3);
        check("replay_score", 32'(bus.score), 0);
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
